// File: rtl/y_serial_sub_pkg.sv
// Shared FSM state encoding for the bit-serial subtractor, so the sequencer and
// benches decode dbg_state identically.
package y_serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/y_sub_bit.sv
// Combinational 1-bit full subtractor cell: d = x - y - bin, with borrow-out.
module y_sub_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/y_serial_sub.sv
// Bit-serial subtractor: diff = a - b, LSB-first, one bit per cycle over WIDTH cycles.
// Optional zero/neg result flags are enabled by defining Y_SUB_FLAGS_EN.
module y_serial_sub
    import y_serial_sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
`ifdef Y_SUB_FLAGS_EN
    output logic             zero,
    output logic             neg,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Handshake: start is sampled only in ST_IDLE; done is a one-cycle pulse and
    // diff/borrow/overflow are valid from that cycle until the next done.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bor_q, bor_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
`ifdef Y_SUB_FLAGS_EN
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
`endif

    logic bit_d, bit_bout;

    y_sub_bit u_bit (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (bor_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        r_sr_d     = r_sr_q;
        cnt_d      = cnt_q;
        bor_d      = bor_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
`ifdef Y_SUB_FLAGS_EN
        zero_d     = zero_q;
        neg_d      = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    // Operand MSBs are kept because the shift regs lose them.
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                r_sr_d = {bit_d, r_sr_q[WIDTH-1:1]};
                bor_d  = bit_bout;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                diff_d     = r_sr_q;
                borrow_d   = bor_q;
                overflow_d = (a_msb_q ^ b_msb_q) & (r_sr_q[WIDTH-1] ^ a_msb_q);
                done_d     = 1'b1;
`ifdef Y_SUB_FLAGS_EN
                zero_d     = (r_sr_q == '0);
                neg_d      = r_sr_q[WIDTH-1];
`endif
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            r_sr_q     <= '0;
            cnt_q      <= '0;
            bor_q      <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef Y_SUB_FLAGS_EN
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            r_sr_q     <= r_sr_d;
            cnt_q      <= cnt_d;
            bor_q      <= bor_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
`ifdef Y_SUB_FLAGS_EN
            zero_q     <= zero_d;
            neg_q      <= neg_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;
`ifdef Y_SUB_FLAGS_EN
    assign zero      = zero_q;
    assign neg       = neg_q;
`endif

endmodule

// File: tb/tb_y_serial_sub.sv
// Directed bench for y_serial_sub: an 8-bit instance for latency, vectors, ignored
// starts and mid-operation reset, plus a 4-bit instance for an exhaustive back-to-back sweep.
module tb_y_serial_sub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, borrow8, ovf8;
    logic [7:0] diff8;
    logic [1:0] st8;
`ifdef Y_SUB_FLAGS_EN
    logic       zero8, neg8;
`endif

    // 4-bit instance
    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, borrow4, ovf4;
    logic [3:0] diff4;
    logic [1:0] st4;
`ifdef Y_SUB_FLAGS_EN
    logic       zero4, neg4;
`endif

    y_serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(ovf8),
`ifdef Y_SUB_FLAGS_EN
        .zero(zero8), .neg(neg8),
`endif
        .dbg_state(st8)
    );

    y_serial_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .overflow(ovf4),
`ifdef Y_SUB_FLAGS_EN
        .zero(zero4), .neg(neg4),
`endif
        .dbg_state(st4)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_done4 = 0;

    always @(negedge clk) if (done4) n_done4++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Hand-computed vectors: a, b, diff, borrow, overflow
    logic [7:0] va[8] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'hAA, 8'h5A, 8'h00, 8'h7F};
    logic [7:0] vb[8] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'hAA, 8'h00, 8'h01, 8'h80};
    logic [7:0] vd[8] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'h00, 8'h5A, 8'hFF, 8'hFF};
    logic       vbr[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       vov[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // Called at a negedge with dut8 idle; returns at the negedge where done8 is seen.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, output int cyc);
        start8 = 1'b1;
        a8 = ta;
        b8 = tb;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!done8) check("op8_timeout", {31'd0, done8}, 32'd1);
    endtask

    initial begin
        int cyc;
        int ndone;
        logic [7:0] first_diff;
        logic [3:0] e4;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_diff", {24'd0, diff8}, 32'd0);
        check("rst_borrow", {31'd0, borrow8}, 32'd0);
        check("rst_ovf", {31'd0, ovf8}, 32'd0);
        check("rst_state", {30'd0, st8}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, first one also checks latency
        for (int i = 0; i < 8; i++) begin
            op8(va[i], vb[i], cyc);
            if (i == 0) check("latency", cyc, 32'd10);
            check($sformatf("v%0d_diff", i), {24'd0, diff8}, {24'd0, vd[i]});
            check($sformatf("v%0d_borrow", i), {31'd0, borrow8}, {31'd0, vbr[i]});
            check($sformatf("v%0d_ovf", i), {31'd0, ovf8}, {31'd0, vov[i]});
`ifdef Y_SUB_FLAGS_EN
            check($sformatf("v%0d_zero", i), {31'd0, zero8}, {31'd0, (vd[i] == 8'h00)});
            check($sformatf("v%0d_neg", i), {31'd0, neg8}, {31'd0, vd[i][7]});
`endif
        end

        // Start while busy is ignored
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_mid", {31'd0, busy8}, 32'd1);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(negedge clk); start8 = 1'b0;
        ndone = 0;
        first_diff = '0;
        for (int k = 0; k < 25; k++) begin
            if (done8) begin
                if (ndone == 0) first_diff = diff8;
                ndone++;
            end
            @(negedge clk);
        end
        check("ign_ndone", ndone, 32'd1);
        check("ign_diff", {24'd0, first_diff}, 32'h0F);

        // Reset in the middle of an operation
        start8 = 1'b1; a8 = 8'h20; b8 = 8'h01;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy8}, 32'd0);
        check("arst_done", {31'd0, done8}, 32'd0);
        check("arst_diff", {24'd0, diff8}, 32'd0);
        check("arst_borrow", {31'd0, borrow8}, 32'd0);
        check("arst_ovf", {31'd0, ovf8}, 32'd0);
        check("arst_state", {30'd0, st8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op8(8'h09, 8'h09, cyc);
        check("post_rst_latency", cyc, 32'd10);
        check("post_rst_diff", {24'd0, diff8}, 32'd0);
        check("post_rst_borrow", {31'd0, borrow8}, 32'd0);
`ifdef Y_SUB_FLAGS_EN
        check("post_rst_zero", {31'd0, zero8}, 32'd1);
`endif

        // WIDTH=4 exhaustive sweep with start held high
        n_done4 = 0;
        start4 = 1'b1;
        for (int p = 0; p < 256; p++) begin
            a4 = p[7:4];
            b4 = p[3:0];
            @(negedge clk);
            if (p == 255) start4 = 1'b0;
            cyc = 1;
            while (!done4 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            e4 = a4 - b4;
            check($sformatf("w4_lat_%0d", p), cyc, 32'd6);
            check($sformatf("w4_diff_%0h_%0h", a4, b4), {28'd0, diff4}, {28'd0, e4});
            check($sformatf("w4_borrow_%0h_%0h", a4, b4), {31'd0, borrow4}, {31'd0, (a4 < b4)});
        end
        repeat (10) @(negedge clk);
        check("w4_ndone", n_done4, 32'd256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
